// File: rtl/uart_tx_8n1_if.sv
// Byte-offer handshake between a producer and the UART transmitter.
//   tx_data  : byte offered by the producer
//   tx_valid : producer has a byte on tx_data
//   tx_ready : transmitter accepts the byte on this rising edge
// A byte transfers on every rising edge where tx_valid and tx_ready are both high.
interface uart_tx_8n1_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with a small transmit FIFO.
//   clk        : single clock, all state changes on its rising edge
//   rst        : synchronous active-high reset, aborts any frame and flushes the FIFO
//   bus        : slave side of the byte-offer handshake (tx_data/tx_valid/tx_ready)
//   tx         : registered serial line, idle high
//   busy       : frame in progress or bytes still queued
//   fifo_count : bytes queued, not counting the byte being shifted out
module uart_tx_8n1 #(
  parameter int unsigned BAUD_TICKS = 5208,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW      = $clog2(BAUD_TICKS)
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_8n1_if.slave        bus,
  output logic                tx,
  output logic                busy,
  output logic [PtrW:0]       fifo_count
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [CntW-1:0] CntReload = CntW'(BAUD_TICKS - 1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push, pop, bit_end, not_empty;
  logic [2:0]      idx_nxt;
  logic [7:0]      head;

  // Readiness depends only on the stored count, so a full FIFO blocks a push even when
  // a pop happens on the same edge.
  assign bus.tx_ready = !rst && (count_q != CountFull);
  assign push         = bus.tx_valid && bus.tx_ready;
  assign not_empty    = (count_q != '0);
  assign bit_end      = (cnt_q == '0);
  assign idx_nxt      = idx_q + 3'd1;
  assign head         = mem_q[rd_ptr_q];

  assign tx         = tx_q;
  assign fifo_count = count_q;
  assign busy       = !rst && ((state_q != StIdle) || not_empty);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (not_empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = CntReload;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = CntReload;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = CntReload;
          idx_d = idx_nxt;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d = shift_q[idx_nxt];
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (not_empty) begin
            pop     = 1'b1;
            shift_d = head;
            cnt_d   = CntReload;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      // Power-of-two depth: pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_data;
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
module tb_uart_tx_8n1;
  localparam int BT = 4;

  logic       clk;
  logic       rst;
  logic       tx, busy;
  logic [2:0] fifo_count;
  logic       tx_d, busy_d;
  logic [2:0] fifo_count_d;

  uart_tx_8n1_if bus ();
  uart_tx_8n1_if bus_d ();

  uart_tx_8n1 #(.BAUD_TICKS(BT), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  uart_tx_8n1 dut_def (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_d),
    .tx         (tx_d),
    .busy       (busy_d),
    .fifo_count (fifo_count_d)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;  // bits[0] is sent first: start, d0..d7, stop
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] fill [6];
  logic [7:0] rx_q [$];
  int         rx_err;
  int         tests  = 0;
  int         fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  // Independent line receiver on the falling edge: samples each bit mid-cell.
  initial begin
    int         cnt;
    bit         active;
    logic [7:0] sh;
    active = 0;
    cnt    = 0;
    sh     = '0;
    rx_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (!active) begin
        if (tx == 1'b0) begin
          active = 1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt % BT == BT / 2 && cnt / BT >= 1 && cnt / BT <= 8) sh[cnt / BT - 1] = tx;
        if (cnt == 9 * BT + BT / 2) begin
          if (tx !== 1'b1) rx_err++;
          rx_q.push_back(sh);
          active = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered at the sample of the first start-bit cycle; leaves at the first cycle after stop.
  task automatic expect_frame(input logic [9:0] exp, input string nm);
    for (int b = 0; b < 10; b++) begin
      logic ok;
      logic seen;
      ok   = 1'b1;
      seen = tx;
      for (int c = 0; c < BT; c++) begin
        if (tx !== exp[b]) begin
          ok   = 1'b0;
          seen = tx;
        end
        step();
      end
      check($sformatf("%s bit%0d", nm, b), {31'd0, ok ? exp[b] : seen}, {31'd0, exp[b]});
    end
  endtask

  initial begin
    int   n;
    logic ok;

    vecs[0] = '{data: 8'h55, bits: 10'b1010101010};
    vecs[1] = '{data: 8'h00, bits: 10'b1000000000};
    vecs[2] = '{data: 8'hA3, bits: 10'b1101000110};
    vecs[3] = '{data: 8'hFF, bits: 10'b1111111110};
    fill    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};

    rst            = 1'b1;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus_d.tx_valid = 1'b0;
    bus_d.tx_data  = 8'h00;

    // Reset state
    step();
    step();
    check("rst tx", {31'd0, tx}, 32'd1);
    check("rst tx_ready", {31'd0, bus.tx_ready}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst tx default", {31'd0, tx_d}, 32'd1);
    rst = 1'b0;
    #1;
    check("ready after release", {31'd0, bus.tx_ready}, 32'd1);
    step();

    // Single frames from idle; tx_data is scrambled after the push
    for (int v = 0; v < 4; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      bus.tx_valid = 1'b1;
      bus.tx_data  = vecs[v].data;
      step();
      bus.tx_valid = 1'b0;
      bus.tx_data  = ~vecs[v].data;
      check({nm, " tx before start"}, {31'd0, tx}, 32'd1);
      check({nm, " count after push"}, {29'd0, fifo_count}, 32'd1);
      step();
      expect_frame(vecs[v].bits, nm);
      check({nm, " busy after frame"}, {31'd0, busy}, 32'd0);
      check({nm, " tx idle"}, {31'd0, tx}, 32'd1);
      repeat (3) step();
    end

    // Back-to-back 0xA3 then 0x0F, no gap between frames
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA3;
    step();
    bus.tx_data  = 8'h0F;
    step();
    bus.tx_valid = 1'b0;
    check("b2b count", {29'd0, fifo_count}, 32'd1);
    expect_frame(10'b1101000110, "b2b first");
    expect_frame(10'b1000011110, "b2b second");
    check("b2b busy end", {31'd0, busy}, 32'd0);
    repeat (3) step();

    // Fill FIFO with tx_valid held high
    rx_q.delete();
    rx_err = 0;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.tx_data = fill[i];
      step();
    end
    bus.tx_data = fill[5];
    check("full ready", {31'd0, bus.tx_ready}, 32'd0);
    check("full count", {29'd0, fifo_count}, 32'd4);
    n  = 0;
    ok = 1'b1;
    while (!bus.tx_ready && n < 100) begin
      if (fifo_count !== 3'd4) ok = 1'b0;
      step();
      n++;
    end
    check("full count held", {31'd0, ok}, 32'd1);
    check("ready after pop", {31'd0, bus.tx_ready}, 32'd1);
    check("count after pop", {29'd0, fifo_count}, 32'd3);
    step();
    bus.tx_valid = 1'b0;
    check("count after 6th", {29'd0, fifo_count}, 32'd4);
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check("fill drained", {31'd0, busy}, 32'd0);
    step();
    check("fill rx count", rx_q.size(), 32'd6);
    check("fill stop bits", rx_err, 32'd0);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check($sformatf("fill byte%0d", i), {24'd0, rx_q[i]}, {24'd0, fill[i]});

    // Reset during data bit 3 of 0xFF with two bytes queued
    rx_q.delete();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    step();
    bus.tx_data  = 8'h12;
    step();
    bus.tx_data  = 8'h34;
    step();
    bus.tx_valid = 1'b0;
    check("abort queued", {29'd0, fifo_count}, 32'd2);
    repeat (16) step();
    check("abort mid d3", {31'd0, tx}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort ready in rst", {31'd0, bus.tx_ready}, 32'd0);
    check("abort busy in rst", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("abort tx", {31'd0, tx}, 32'd1);
    check("abort count", {29'd0, fifo_count}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort ready", {31'd0, bus.tx_ready}, 32'd1);
    ok = 1'b1;
    repeat (100) begin
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      step();
    end
    check("abort line quiet", {31'd0, ok}, 32'd1);
    check("abort no frames", rx_q.size(), 32'd0);

    // Default baud: 0x41 start-bit width and whole-frame length
    bus_d.tx_valid = 1'b1;
    bus_d.tx_data  = 8'h41;
    step();
    bus_d.tx_valid = 1'b0;
    step();
    n = 0;
    while (tx_d == 1'b0 && n < 6000) begin
      n++;
      step();
    end
    check("default start width", n, 32'd5208);
    while (busy_d && n < 60000) begin
      n++;
      step();
    end
    check("default frame length", n, 32'd52080);
    check("default tx idle", {31'd0, tx_d}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_8n1.md
UART_TX_8N1 -- requirements
Module: uart_tx_8n1

Interface
REQ-001 SHALL have parameter BAUD_TICKS, default 5208, clocks per bit (50 MHz / 9600 baud); legal range 2..8191.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries in the transmit FIFO; a power of 2, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tx_data  input  8  byte to transmit, sampled when tx_valid and tx_ready are both high.
REQ-006 SHALL have port tx_valid  input  1  byte-offer strobe from the producer.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL have port fifo_count  output  log2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.

Function
REQ-011 SHALL send 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 SHALL hold each bit on tx for exactly BAUD_TICKS clocks, so one frame lasts 10*BAUD_TICKS clocks.
REQ-013 SHALL accept a byte into the FIFO tail on any rising edge where tx_valid=1 and tx_ready=1; otherwise the FIFO tail is unchanged.
REQ-014 SHALL drive tx_ready = !rst && (fifo_count != FIFO_DEPTH), combinationally.
REQ-015 SHALL block pushes when the FIFO is full, even if a pop occurs on the same edge.
REQ-016 SHALL perform a simultaneous push and pop on a non-full, non-empty FIFO in one cycle, leaving fifo_count unchanged.
REQ-017 SHALL implement an FSM with four states:
- IDLE -> START when the FIFO is non-empty: pop the head into the shift register; tx=0 from the next edge.
- START -> DATA after BAUD_TICKS clocks.
- DATA -> STOP after 8*BAUD_TICKS clocks; a 3-bit index increments once per bit.
- STOP -> START if the FIFO is non-empty at the last stop-bit clock (pop on that edge, no idle gap); otherwise STOP -> IDLE.
REQ-018 SHALL make tx fall exactly 1 clock after the accepting edge when the block is IDLE with an empty FIFO.
REQ-019 SHALL use a baud counter that reloads to BAUD_TICKS-1 on every bit boundary and counts down to 0; a bit ends on the clock where the counter reaches 0.
REQ-020 SHALL keep the transmitted byte stable even if the producer changes tx_data mid-frame, because the byte is latched at pop.
REQ-021 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH with no lost or duplicated bytes.
REQ-022 SHALL drive busy = (state != IDLE) || (fifo_count != 0).
REQ-023 SHALL ignore tx_valid while tx_ready=0, with no side effects.

Reset
REQ-024 SHALL, on any rising edge with rst=1, set tx=1, state=IDLE, fifo_count=0, pointers=0, baud counter=0 and bit index=0.
REQ-025 SHALL, when rst is asserted mid-frame, abort the frame: tx=1 from the next edge, queued bytes discarded, no partial resumption after release.
REQ-026 SHALL hold busy=0 and tx_ready=0 while rst=1; tx_ready=1 on the first cycle after release.

Verification (BAUD_TICKS=4, FIFO_DEPTH=4 unless stated)
REQ-027 SHALL pass: single byte 0x55 pushed after reset -> tx low 1 clk after push; bit sequence 0,1,0,1,0,1,0,1,0,1, each 4 clks; busy falls after 40 clks; tx stays 1.
REQ-028 SHALL pass: back-to-back 0xA3,0x0F pushed on consecutive clocks -> two frames, stop bit of the first followed immediately by the start of the second, 80 clks total, LSB-first data 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
REQ-029 SHALL pass: tx_valid held high with 6 distinct bytes while idle -> first popped, next 4 queued, tx_ready=0 with fifo_count=4; 6th accepted only after the next pop; all 6 emitted in order.
REQ-030 SHALL pass: rst asserted for 1 clk during data bit 3 of 0xFF with 2 bytes queued -> tx=1 next edge, fifo_count=0, busy=0; no further frames.
REQ-031 SHALL pass: push 0x00 and change tx_data to 0xFF during the frame -> line shows 8 zero data bits.
REQ-032 SHALL pass: default BAUD_TICKS=5208, byte 0x41 -> start-bit low width 5208 clks; frame 52080 clks.
